// File: rtl/ber_sequencer.sv
// ber_sequencer: controls one BER measurement (clear, wait for sync, count a
// window of bits) and latches the resulting bit/error counts or a sync timeout.
module ber_sequencer #(
    parameter int NB_CNT       = 64,
    parameter int SYNC_TIMEOUT = 300000
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_ack,
    input  logic [NB_CNT-1:0] i_window,
    input  logic              i_valid,
    input  logic [NB_CNT-1:0] i_ber_bits,
    input  logic [NB_CNT-1:0] i_ber_errors,
    output logic              o_ber_reset,
    output logic              o_ber_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout,
    output logic [NB_CNT-1:0] o_bits,
    output logic [NB_CNT-1:0] o_errors
);
    localparam int CW = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT = CW'(SYNC_TIMEOUT);

    typedef enum logic [2:0] {IDLE, CLEAR, SYNC, MEASURE, DONE} state_t;

    state_t state_q, state_d;
    logic clr_q, clr_d;
    logic [CW-1:0] sync_q, sync_d, sync_inc;
    logic [NB_CNT-1:0] win_q, win_d, win_sel;
    logic [NB_CNT-1:0] bits_q, bits_d, errors_q, errors_d;
    logic timeout_q, timeout_d;
    logic ber_reset_q, ber_reset_d, busy_q, busy_d, done_q, done_d;

    assign win_sel = (i_window == '0) ? NB_CNT'(1) : i_window;

    always_comb begin
        state_d   = state_q;
        clr_d     = 1'b0;
        sync_d    = '0;
        sync_inc  = sync_q + CW'(i_valid);
        win_d     = win_q;
        bits_d    = bits_q;
        errors_d  = errors_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: if (i_start) begin
                state_d = CLEAR;
                win_d   = win_sel;
            end
            CLEAR: begin
                clr_d   = 1'b1;
                state_d = clr_q ? SYNC : CLEAR;
            end
            SYNC: begin
                sync_d = sync_inc;
                // sync detect takes priority over a simultaneous timeout
                if (i_ber_bits != '0) state_d = MEASURE;
                else if (sync_inc >= TIMEOUT) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    bits_d    = '0;
                    errors_d  = '0;
                end
            end
            MEASURE: if (i_ber_bits >= win_q) begin
                state_d   = DONE;
                timeout_d = 1'b0;
                bits_d    = i_ber_bits;
                errors_d  = i_ber_errors;
            end
            DONE: if (i_start) begin
                state_d = CLEAR;
                win_d   = win_sel;
            end else if (i_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_abort) begin
            state_d   = IDLE;
            win_d     = win_q;
            bits_d    = bits_q;
            errors_d  = errors_q;
            timeout_d = timeout_q;
        end
        ber_reset_d = (state_d == IDLE) || (state_d == CLEAR) || (state_d == DONE);
        busy_d      = (state_d == CLEAR) || (state_d == SYNC) || (state_d == MEASURE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            clr_q       <= 1'b0;
            sync_q      <= '0;
            win_q       <= '0;
            bits_q      <= '0;
            errors_q    <= '0;
            timeout_q   <= 1'b0;
            ber_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            sync_q      <= sync_d;
            win_q       <= win_d;
            bits_q      <= bits_d;
            errors_q    <= errors_d;
            timeout_q   <= timeout_d;
            ber_reset_q <= ber_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_ber_valid = i_valid && ((state_q == SYNC) || (state_q == MEASURE));
    assign o_ber_reset = ber_reset_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_timeout   = timeout_q;
    assign o_bits      = bits_q;
    assign o_errors    = errors_q;
endmodule

// File: tb/tb_ber_sequencer.sv
// tb_ber_sequencer: drives ber_sequencer against a BER-counter stub and checks
// every cycle against a phase-level reference model, plus directed literals.
module tb_ber_sequencer;
    localparam int NB = 16;
    localparam int TO = 1000;
    localparam int P_IDLE = 0, P_CLEAR = 1, P_SYNC = 2, P_MEAS = 3, P_DONE = 4;

    logic clk = 1'b0;
    logic i_reset = 1'b1, i_start = 1'b0, i_abort = 1'b0, i_ack = 1'b0, i_valid = 1'b0;
    logic [NB-1:0] i_window = '0, i_ber_bits = '0, i_ber_errors = '0;
    logic o_ber_reset, o_ber_valid, o_busy, o_done, o_timeout;
    logic [NB-1:0] o_bits, o_errors;

    int n_cmp = 0, n_bad = 0;
    int m_phase = P_IDLE, m_clr = 0, m_vseen = 0, m_win = 0, m_bits = 0, m_err = 0;
    bit m_to = 1'b0;
    int s_after = 0, s_vcnt = 0, s_bits = 0, s_err = 0, s_per = 100, s_max = 7;
    bit tg = 1'b0;

    always #5 clk = ~clk;

    ber_sequencer #(.NB_CNT(NB), .SYNC_TIMEOUT(TO)) dut (
        .clock(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
        .i_ack(i_ack), .i_window(i_window), .i_valid(i_valid),
        .i_ber_bits(i_ber_bits), .i_ber_errors(i_ber_errors),
        .o_ber_reset(o_ber_reset), .o_ber_valid(o_ber_valid), .o_busy(o_busy),
        .o_done(o_done), .o_timeout(o_timeout), .o_bits(o_bits), .o_errors(o_errors)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check();
        chk("ber_reset", o_ber_reset, m_phase == P_IDLE || m_phase == P_CLEAR || m_phase == P_DONE);
        chk("ber_valid", o_ber_valid, i_valid && (m_phase == P_SYNC || m_phase == P_MEAS));
        chk("busy", o_busy, m_phase == P_CLEAR || m_phase == P_SYNC || m_phase == P_MEAS);
        chk("done", o_done, m_phase == P_DONE);
        chk("timeout", o_timeout, m_to);
        chk("bits", o_bits, m_bits);
        chk("errors", o_errors, m_err);
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_clr = 0; m_vseen = 0; m_win = 0; m_bits = 0; m_err = 0; m_to = 1'b0;
    endtask

    task automatic model_update();
        int wsel;
        wsel = (i_window == '0) ? 1 : int'(i_window);
        if (i_reset) model_reset();
        else if (i_abort) m_phase = P_IDLE;
        else case (m_phase)
            P_IDLE: if (i_start) begin m_phase = P_CLEAR; m_clr = 2; m_win = wsel; end
            P_CLEAR: begin
                m_clr--;
                if (m_clr == 0) begin m_phase = P_SYNC; m_vseen = 0; end
            end
            P_SYNC: begin
                m_vseen += int'(i_valid);
                if (i_ber_bits != '0) m_phase = P_MEAS;
                else if (m_vseen >= TO) begin m_phase = P_DONE; m_to = 1'b1; m_bits = 0; m_err = 0; end
            end
            P_MEAS: if (int'(i_ber_bits) >= m_win) begin
                m_phase = P_DONE; m_to = 1'b0; m_bits = int'(i_ber_bits); m_err = int'(i_ber_errors);
            end
            default: if (i_start) begin m_phase = P_CLEAR; m_clr = 2; m_win = wsel; end
                     else if (i_ack) m_phase = P_IDLE;
        endcase
    endtask

    // BER counter stand-in: silent for s_after valid samples, then counts bits
    task automatic stub_update(input logic rs, input logic vs);
        if (rs) begin s_vcnt = 0; s_bits = 0; s_err = 0; end
        else if (vs) begin
            if (s_vcnt < s_after) s_vcnt++;
            else begin
                s_bits++;
                if (s_bits % s_per == 0 && s_err < s_max) s_err++;
            end
        end
        i_ber_bits = NB'(s_bits);
        i_ber_errors = NB'(s_err);
    endtask

    task automatic step(input logic v, input logic s, input logic a, input logic k);
        logic rs, vs;
        @(negedge clk);
        i_valid = v; i_start = s; i_abort = a; i_ack = k;
        #1;
        check();
        rs = o_ber_reset;
        vs = o_ber_valid;
        model_update();
        @(posedge clk);
        #1;
        stub_update(rs, vs);
    endtask

    // vprob < 0 selects strict 1/0 toggling of i_valid
    task automatic run_to_end(input int limit, input int vprob, input bit noise);
        int c;
        logic v;
        c = 0;
        while ((m_phase == P_CLEAR || m_phase == P_SYNC || m_phase == P_MEAS) && c < limit) begin
            tg = ~tg;
            v = (vprob < 0) ? tg : ($urandom_range(99) < vprob);
            if (noise) step(v, $urandom_range(7) == 0, $urandom_range(999) < 2, $urandom_range(7) == 0);
            else step(v, 1'b0, 1'b0, 1'b0);
            c++;
        end
        if (c >= limit) begin
            n_cmp++; n_bad++;
            $display("FAIL run_bound: still busy after %0d cycles (phase %0d)", c, m_phase);
        end
    endtask

    initial begin
        int c, sc;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        i_reset = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);

        i_window = 16'd5;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_abort_idle_busy", o_busy, 0);

        i_window = 16'd1000; s_after = 300;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        run_to_end(5000, 100, 1'b0);
        chk("w1000_done", o_done, 1);
        chk("w1000_bits", o_bits, 1000);
        chk("w1000_errors", o_errors, 7);
        chk("w1000_timeout", o_timeout, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        s_after = 10;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        c = 0;
        while (!(m_phase == P_MEAS && i_ber_bits == 16'd500) && c < 5000) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            c++;
        end
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("abort_busy", o_busy, 0);
        chk("abort_ber_reset", o_ber_reset, 1);
        chk("abort_done", o_done, 0);
        chk("abort_bits_kept", o_bits, 1000);
        chk("abort_errors_kept", o_errors, 7);

        i_window = 16'd10; s_after = 5000;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        c = 0; sc = 0;
        while ((m_phase == P_CLEAR || m_phase == P_SYNC) && c < 3000) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (o_busy && !o_ber_reset) sc++;
            c++;
        end
        chk("timeout_sync_cycles", sc, 1000);
        chk("timeout_flag", o_timeout, 1);
        chk("timeout_bits", o_bits, 0);
        chk("timeout_errors", o_errors, 0);
        chk("timeout_done", o_done, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        i_window = 16'd0; s_after = 3; tg = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        run_to_end(1000, -1, 1'b0);
        chk("w0_bits", o_bits, 1);
        chk("w0_timeout", o_timeout, 0);

        i_window = 16'd20; s_after = 4;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("restart_clr1_reset", o_ber_reset, 1);
        chk("restart_clr1_busy", o_busy, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_clr2_reset", o_ber_reset, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_sync_reset", o_ber_reset, 0);
        run_to_end(1000, 100, 1'b0);
        chk("restart_bits", o_bits, 20);
        chk("restart_errors", o_errors, 0);

        i_window = 16'd50; s_after = 5000;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2 i_reset = 1'b1;
        #1;
        chk("arst_ber_reset", o_ber_reset, 1);
        chk("arst_busy", o_busy, 0);
        chk("arst_done", o_done, 0);
        chk("arst_timeout", o_timeout, 0);
        chk("arst_bits", o_bits, 0);
        chk("arst_errors", o_errors, 0);
        chk("arst_ber_valid", o_ber_valid, 0);
        model_reset();
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        i_reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        repeat (25) begin
            s_per = $urandom_range(2, 9);
            s_max = $urandom_range(0, 10);
            s_after = ($urandom_range(7) == 0) ? 3000 : $urandom_range(0, 25);
            i_window = NB'($urandom_range(0, 40));
            if ($urandom_range(2) == 0) step(1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b1, 1'b1, 1'b0, $urandom_range(1) == 1);
            run_to_end(20000, $urandom_range(30, 100), 1'b1);
            repeat ($urandom_range(0, 3)) step($urandom_range(1) == 1, 1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
